// File: rtl/seven_segment_reader.sv
// Receive side of the multiplexed 7-segment bus: rebuilds whole frames from
// strobed beats, decodes them, filters glitches and publishes changes via valid/ready.
module seven_segment_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [6:0]                  seg,
    input  logic [NUM_DIGITS-1:0]       dig_sel,
    input  logic                        seg_valid,
    output logic [4*NUM_DIGITS-1:0]     value,
    output logic [NUM_DIGITS-1:0]       digit_err,
    output logic                        upd_valid,
    input  logic                        upd_ready,
    output logic                        seq_err,
    output logic                        overrun,
    output logic [$clog2(NUM_DIGITS):0] dbg_state_o
);
    // Handshake: an update transfers on any rising edge where upd_valid and
    // upd_ready are both high; value/digit_err stay frozen while upd_valid is
    // high unless a newer frame is published, which also raises overrun if unaccepted.

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] FIRST_SEL = NUM_DIGITS'(1);
    localparam logic [3:0]            SF        = 4'(STABLE_FRAMES);

    typedef enum logic {IDLE, COLLECT} state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   codes_q, codes_d;
    logic [NUM_DIGITS-1:0]     errs_q, errs_d;
    logic [5*NUM_DIGITS-1:0]   prev_q, prev_d;
    logic [3:0]                stable_q, stable_d;
    logic                      published_q, published_d;
    logic [4*NUM_DIGITS-1:0]   value_q, value_d;
    logic [NUM_DIGITS-1:0]     derr_q, derr_d;
    logic                      valid_q, valid_d;
    logic                      seq_err_q, seq_err_d;
    logic                      overrun_q, overrun_d;

    logic [4:0]                dec;
    logic [NUM_DIGITS-1:0]     exp_sel;
    logic                      capture, frame_done, publish, xfer;
    logic [IDX_W-1:0]          cap_idx;
    logic [3:0]                stable_next;
    logic [5*NUM_DIGITS-1:0]   frame;

    // Returns {err, code}; the dash is a legal blank-ish symbol, not an error.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1111110: decode = 5'h00;
            7'b0110000: decode = 5'h01;
            7'b1101101: decode = 5'h02;
            7'b1111001: decode = 5'h03;
            7'b0110011: decode = 5'h04;
            7'b1011011: decode = 5'h05;
            7'b1011111: decode = 5'h06;
            7'b1110000: decode = 5'h07;
            7'b1111111: decode = 5'h08;
            7'b1111011: decode = 5'h09;
            7'b0000001: decode = 5'h0F;
            default:    decode = 5'h1E;
        endcase
    endfunction

    assign dec     = decode(seg);
    assign exp_sel = FIRST_SEL << idx_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        codes_d    = codes_q;
        errs_d     = errs_q;
        capture    = 1'b0;
        cap_idx    = idx_q;
        frame_done = 1'b0;
        seq_err_d  = 1'b0;
        if (seg_valid) begin
            if (state_q == IDLE) begin
                if (dig_sel == FIRST_SEL) begin
                    capture = 1'b1;
                    cap_idx = '0;
                    state_d = COLLECT;
                    idx_d   = IDX_W'(1);
                end
            end else if (dig_sel == exp_sel) begin
                capture = 1'b1;
                if (idx_q == LAST_IDX) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                    idx_d      = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else if (dig_sel == FIRST_SEL) begin
                // A stray digit-0 strobe is treated as the start of a fresh frame.
                seq_err_d = 1'b1;
                capture   = 1'b1;
                cap_idx   = '0;
                idx_d     = IDX_W'(1);
            end else begin
                seq_err_d = 1'b1;
                state_d   = IDLE;
                idx_d     = '0;
            end
        end
        if (capture) begin
            codes_d[4*int'(cap_idx) +: 4] = dec[3:0];
            errs_d[cap_idx]               = dec[4];
        end
    end

    always_comb begin
        frame       = {errs_d, codes_d};
        stable_next = (frame != prev_q) ? 4'd1 :
                      (stable_q < SF)   ? stable_q + 4'd1 : SF;
        publish     = frame_done && (stable_next == SF) &&
                      ((frame != {derr_q, value_q}) || !published_q);
        xfer        = valid_q && upd_ready;

        prev_d      = prev_q;
        stable_d    = stable_q;
        published_d = published_q;
        value_d     = value_q;
        derr_d      = derr_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        if (frame_done) begin
            prev_d   = frame;
            stable_d = stable_next;
        end
        if (publish) begin
            value_d     = codes_d;
            derr_d      = errs_d;
            valid_d     = 1'b1;
            published_d = 1'b1;
            overrun_d   = valid_q && !upd_ready;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            codes_q     <= '0;
            errs_q      <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
            published_q <= 1'b0;
            value_q     <= '0;
            derr_q      <= '0;
            valid_q     <= 1'b0;
            seq_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            codes_q     <= codes_d;
            errs_q      <= errs_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            published_q <= published_d;
            value_q     <= value_d;
            derr_q      <= derr_d;
            valid_q     <= valid_d;
            seq_err_q   <= seq_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign value       = value_q;
    assign digit_err   = derr_q;
    assign upd_valid   = valid_q;
    assign seq_err     = seq_err_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = {state_q == COLLECT, idx_q};

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader: a frame-level reference model checked
// every cycle, plus literal expectations at the interesting points.
module tb_seven_segment_reader;
    localparam int N  = 4;
    localparam int SF = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [6:0]     seg = '0;
    logic [N-1:0]   dig_sel = '0;
    logic           seg_valid = 1'b0;
    logic           upd_ready = 1'b1;
    logic [4*N-1:0] value;
    logic [N-1:0]   digit_err;
    logic           upd_valid, seq_err, overrun;
    logic [2:0]     dbg_state;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    seven_segment_reader #(.NUM_DIGITS(N), .STABLE_FRAMES(SF)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel), .seg_valid(seg_valid),
        .value(value), .digit_err(digit_err), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .seq_err(seq_err), .overrun(overrun), .dbg_state_o(dbg_state)
    );

    // Symbol to segment pattern (a..g); 15 = dash, anything unknown = blank.
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
            3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
            6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
            9: return 7'b1111011;  15: return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    // Inverse lookup of the symbol table; unmatched patterns become error code E.
    function automatic logic [4:0] model_decode(input logic [6:0] p);
        for (int d = 0; d < 10; d++)
            if (seg_of(d) == p) return {1'b0, 4'(d)};
        if (p == seg_of(15)) return 5'h0F;
        return 5'h1E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: raw patterns collected per frame, decoded only when the frame closes.
    logic [6:0]     m_cap [N];
    int             m_next;      // 0 = waiting for digit 0, else next expected digit
    int             m_stable;
    logic [5*N-1:0] m_prev;
    logic [4*N-1:0] m_value;
    logic [N-1:0]   m_err;
    bit             m_pub, m_valid, m_seq_err, m_overrun;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_next = 0; m_stable = 0; m_prev = '0; m_value = '0; m_err = '0;
            m_pub = 0; m_valid = 0; m_seq_err = 0; m_overrun = 0;
            cmp_en = 1;
        end else begin
            bit             done, pub, xfer;
            int             ones, pos;
            logic [4*N-1:0] fc;
            logic [N-1:0]   fe;
            logic [4:0]     de;
            done = 0; pub = 0; m_seq_err = 0; m_overrun = 0;
            xfer = m_valid && upd_ready;
            if (seg_valid) begin
                ones = 0; pos = -1;
                for (int i = 0; i < N; i++)
                    if (dig_sel[i]) begin ones++; pos = i; end
                if (m_next == 0) begin
                    if (ones == 1 && pos == 0) begin m_cap[0] = seg; m_next = 1; end
                end else if (ones == 1 && pos == m_next) begin
                    m_cap[pos] = seg;
                    m_next++;
                    if (m_next == N) begin done = 1; m_next = 0; end
                end else if (ones == 1 && pos == 0) begin
                    m_seq_err = 1; m_cap[0] = seg; m_next = 1;
                end else begin
                    m_seq_err = 1; m_next = 0;
                end
            end
            if (done) begin
                for (int i = 0; i < N; i++) begin
                    de = model_decode(m_cap[i]);
                    fc[4*i +: 4] = de[3:0];
                    fe[i] = de[4];
                end
                m_stable = ({fe, fc} == m_prev) ? ((m_stable + 1 > SF) ? SF : m_stable + 1) : 1;
                m_prev = {fe, fc};
                pub = (m_stable == SF) && ((fc != m_value) || (fe != m_err) || !m_pub);
                if (pub) begin
                    m_overrun = m_valid && !upd_ready;
                    m_value = fc; m_err = fe; m_valid = 1; m_pub = 1;
                end
            end
            if (!pub && xfer) m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_value", 32'(value), 32'(m_value));
            chk("cyc_digit_err", 32'(digit_err), 32'(m_err));
            chk("cyc_upd_valid", 32'(upd_valid), 32'(m_valid));
            chk("cyc_seq_err", 32'(seq_err), 32'(m_seq_err));
            chk("cyc_overrun", 32'(overrun), 32'(m_overrun));
        end
    end

    task automatic beat(input logic [6:0] s, input logic [N-1:0] sel);
        @(posedge clk); #1;
        seg = s; dig_sel = sel; seg_valid = 1'b1;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        seg = '0; dig_sel = '0; seg_valid = 1'b0;
    endtask

    task automatic frame(input int d0, input int d1, input int d2, input int d3);
        beat(seg_of(d0), 4'b0001);
        beat(seg_of(d1), 4'b0010);
        beat(seg_of(d2), 4'b0100);
        beat(seg_of(d3), 4'b1000);
    endtask

    initial begin
        @(posedge clk); #1;
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_upd_valid", 32'(upd_valid), 32'h0);
        chk("rst_dbg_state", 32'(dbg_state), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Two identical frames publish on the edge that samples the last beat.
        frame(1, 2, 3, 4); idle();
        chk("s1_first_no_update", 32'(upd_valid), 32'h0);
        frame(1, 2, 3, 4); idle();
        chk("s1_value", 32'(value), 32'h4321);
        chk("s1_digit_err", 32'(digit_err), 32'h0);
        chk("s1_upd_valid", 32'(upd_valid), 32'h1);
        idle();
        chk("s1_upd_valid_clear", 32'(upd_valid), 32'h0);
        frame(1, 2, 3, 4); idle();
        chk("s1_no_republish", 32'(upd_valid), 32'h0);

        // A bad digit breaks stability; the bad frame itself then publishes with an error flag.
        frame(5, 6, 7, 8); idle();
        frame(5, 6, 14, 8); idle();
        chk("s2_no_8765", 32'(upd_valid), 32'h0);
        frame(5, 6, 14, 8); idle();
        chk("s2_value", 32'(value), 32'h8E65);
        chk("s2_digit_err", 32'(digit_err), 32'h4);
        frame(0, 1, 2, 15); idle();
        frame(0, 1, 2, 15); idle();
        chk("s2_dash_value", 32'(value), 32'hF210);
        chk("s2_dash_err", 32'(digit_err), 32'h0);

        // Non-one-hot strobe mid-frame drops to idle; realignment waits for digit 0.
        beat(seg_of(9), 4'b0001); beat(seg_of(8), 4'b0010); beat(seg_of(7), 4'b0110); idle();
        chk("s3_seq_err", 32'(seq_err), 32'h1);
        idle();
        chk("s3_seq_err_pulse", 32'(seq_err), 32'h0);
        beat(seg_of(1), 4'b0010); beat(seg_of(2), 4'b0100); beat(seg_of(3), 4'b1000); idle();
        chk("s3_ignored_idle", 32'(dbg_state), 32'h0);
        frame(9, 8, 7, 6); idle();
        frame(9, 8, 7, 6); idle();
        chk("s3_value", 32'(value), 32'h6789);

        // Digit-0 strobe at k=3 restarts the frame with that beat as digit 0.
        beat(seg_of(5), 4'b0001); beat(seg_of(5), 4'b0010); beat(seg_of(5), 4'b0100);
        beat(seg_of(5), 4'b0001); idle();
        chk("s4_seq_err", 32'(seq_err), 32'h1);
        chk("s4_restart_state", 32'(dbg_state), 32'h5);
        beat(seg_of(5), 4'b0010); beat(seg_of(5), 4'b0100); beat(seg_of(5), 4'b1000); idle();
        chk("s4_first_no_update", 32'(upd_valid), 32'h0);
        frame(5, 5, 5, 5); idle();
        chk("s4_value", 32'(value), 32'h5555);
        idle();

        // Replacing an unaccepted update raises overrun once.
        upd_ready = 1'b0;
        frame(1, 1, 1, 1); idle();
        frame(1, 1, 1, 1); idle();
        chk("s5_value_1111", 32'(value), 32'h1111);
        chk("s5_no_overrun", 32'(overrun), 32'h0);
        frame(2, 2, 2, 2); idle();
        frame(2, 2, 2, 2); idle();
        chk("s5_overrun", 32'(overrun), 32'h1);
        chk("s5_value_2222", 32'(value), 32'h2222);
        idle();
        chk("s5_overrun_pulse", 32'(overrun), 32'h0);
        chk("s5_valid_held", 32'(upd_valid), 32'h1);
        upd_ready = 1'b1;
        idle();
        chk("s5_valid_taken", 32'(upd_valid), 32'h0);

        // Reset mid-frame with a pending update clears everything.
        upd_ready = 1'b0;
        frame(3, 3, 3, 3); idle();
        frame(3, 3, 3, 3); idle();
        chk("s6_pending", 32'(upd_valid), 32'h1);
        beat(seg_of(3), 4'b0001); beat(seg_of(3), 4'b0010);
        @(posedge clk); #1;
        seg_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("s6_rst_value", 32'(value), 32'h0);
        chk("s6_rst_valid", 32'(upd_valid), 32'h0);
        chk("s6_rst_state", 32'(dbg_state), 32'h0);
        upd_ready = 1'b1;
        beat(seg_of(4), 4'b0010); beat(seg_of(4), 4'b0100); beat(seg_of(4), 4'b1000); idle();
        chk("s6_ignored", 32'(dbg_state), 32'h0);
        frame(4, 4, 4, 4); idle();
        frame(4, 4, 4, 4); idle();
        chk("s6_value", 32'(value), 32'h4444);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
